// File: rtl/line_buffer_scheduler.sv
// Scheduler for the three-bank pixel-updated flag store. It rotates the
// update bank per scanline, sweeps the clear address and arbitrates two writers.
module line_buffer_scheduler #(
  parameter int ADDR_W    = 8,
  parameter int CLEAR_LEN = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              req0,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [3:0]        req0_mask,
  input  logic              req1,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [3:0]        req1_mask,
  output logic              gnt0,
  output logic              gnt1,
  output logic [1:0]        update_switch,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              write_pixel,
  output logic [3:0]        pixel_write_updated,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              clear_active,
  output logic              overrun
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLEAR_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  // Bank rotation 0 -> 1 -> 2 -> 0; the unused code 3 falls back to bank 0.
  function automatic logic [1:0] next_bank(input logic [1:0] bank);
    logic [1:0] nb;
    case (bank)
      2'd0:    nb = 2'd1;
      2'd1:    nb = 2'd2;
      2'd2:    nb = 2'd0;
      default: nb = 2'd0;
    endcase
    return nb;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [1:0]        bank_r, bank_nxt_s;
  logic [ADDR_W-1:0] clr_addr_r, clr_addr_nxt_s;
  logic              clr_on_r, clr_on_nxt_s;
  logic              ovr_r, ovr_nxt_s;
  logic              rr_last_r, rr_last_nxt_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_nxt_s;
  logic [3:0]        wr_mask_r, wr_mask_nxt_s;
  logic              wr_en_r, wr_en_nxt_s;
  logic              grant_ok_s, gnt0_s, gnt1_s, line_evt_s;

  // Combinational round-robin grant; any boundary cycle blocks both requesters.
  always_comb begin
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    grant_ok_s = (state_r == ST_ACTIVE) && !line_start && !frame_start;
    if (grant_ok_s) begin
      if (req0 && req1) begin
        if (rr_last_r) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end else begin
        gnt0_s = req0;
        gnt1_s = req1;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Next-state for FSM, bank rotation, clear sweep, overrun and write stage.
  always_comb begin
    state_nxt_s    = state_r;
    bank_nxt_s     = bank_r;
    clr_addr_nxt_s = clr_addr_r;
    clr_on_nxt_s   = clr_on_r;
    ovr_nxt_s      = ovr_r;
    rr_last_nxt_s  = rr_last_r;
    wr_addr_nxt_s  = wr_addr_r;
    wr_mask_nxt_s  = wr_mask_r;
    wr_en_nxt_s    = 1'b0;
    line_evt_s     = (state_r == ST_ACTIVE) && line_start && !frame_start;

    case (state_r)
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: state_nxt_s = ST_ACTIVE;
      default:   state_nxt_s = ST_IDLE;
    endcase

    if (frame_start) begin
      bank_nxt_s     = 2'd0;
      clr_addr_nxt_s = '0;
      clr_on_nxt_s   = 1'b1;
    end else if (line_evt_s) begin
      bank_nxt_s     = next_bank(bank_r);
      clr_addr_nxt_s = '0;
      clr_on_nxt_s   = 1'b1;
      if (clr_on_r) begin
        ovr_nxt_s = 1'b1;
      end else begin
        ovr_nxt_s = ovr_r;
      end
    end else if (clr_on_r) begin
      if (clr_addr_r == LAST_ADDR) begin
        clr_addr_nxt_s = '0;
        clr_on_nxt_s   = 1'b0;
      end else begin
        clr_addr_nxt_s = clr_addr_r + ADDR_ONE;
        clr_on_nxt_s   = 1'b1;
      end
    end else begin
      clr_addr_nxt_s = clr_addr_r;
      clr_on_nxt_s   = 1'b0;
    end

    // Address and mask hold their last value when nothing is granted.
    if (gnt0_s) begin
      rr_last_nxt_s = 1'b0;
      wr_addr_nxt_s = req0_addr;
      wr_mask_nxt_s = req0_mask;
      wr_en_nxt_s   = 1'b1;
    end else if (gnt1_s) begin
      rr_last_nxt_s = 1'b1;
      wr_addr_nxt_s = req1_addr;
      wr_mask_nxt_s = req1_mask;
      wr_en_nxt_s   = 1'b1;
    end else begin
      wr_en_nxt_s   = 1'b0;
    end
  end

  // State and output registers; reset aborts any sweep or pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      bank_r     <= 2'd0;
      clr_addr_r <= '0;
      clr_on_r   <= 1'b0;
      ovr_r      <= 1'b0;
      rr_last_r  <= 1'b1;
      wr_addr_r  <= '0;
      wr_mask_r  <= 4'h0;
      wr_en_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      bank_r     <= bank_nxt_s;
      clr_addr_r <= clr_addr_nxt_s;
      clr_on_r   <= clr_on_nxt_s;
      ovr_r      <= ovr_nxt_s;
      rr_last_r  <= rr_last_nxt_s;
      wr_addr_r  <= wr_addr_nxt_s;
      wr_mask_r  <= wr_mask_nxt_s;
      wr_en_r    <= wr_en_nxt_s;
    end
  end

  assign gnt0                = gnt0_s;
  assign gnt1                = gnt1_s;
  assign update_switch       = bank_r;
  assign pixel_addr          = wr_addr_r;
  assign write_pixel         = wr_en_r;
  assign pixel_write_updated = wr_mask_r;
  assign clear_addr          = clr_addr_r;
  assign clear_active        = clr_on_r;
  assign overrun             = ovr_r;

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Self-checking bench for line_buffer_scheduler: vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_line_buffer_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0, line_start = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] req0_addr = 8'h00, req1_addr = 8'h00;
  logic [3:0] req0_mask = 4'h0, req1_mask = 4'h0;
  logic       gnt0, gnt1, write_pixel, clear_active, overrun;
  logic [1:0] update_switch;
  logic [7:0] pixel_addr, clear_addr;
  logic [3:0] pixel_write_updated;

  line_buffer_scheduler #(.ADDR_W(8), .CLEAR_LEN(256)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .line_start(line_start),
    .req0(req0), .req0_addr(req0_addr), .req0_mask(req0_mask),
    .req1(req1), .req1_addr(req1_addr), .req1_mask(req1_mask),
    .gnt0(gnt0), .gnt1(gnt1), .update_switch(update_switch), .pixel_addr(pixel_addr),
    .write_pixel(write_pixel), .pixel_write_updated(pixel_write_updated),
    .clear_addr(clear_addr), .clear_active(clear_active), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: scanline/frame view of the scheduler.
  bit         m_active, m_clr_on, m_ovr, m_last, m_wr;
  int         m_bank, m_clr_addr;
  logic [7:0] m_addr;
  logic [3:0] m_mask;
  bit         act_g0, act_g1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_clr_on = 0; m_ovr = 0; m_last = 1; m_wr = 0;
    m_bank = 0; m_clr_addr = 0; m_addr = 8'h00; m_mask = 4'h0;
  endtask

  task automatic check_regs();
    chk("update_switch", int'(update_switch), m_bank);
    chk("write_pixel", int'(write_pixel), int'(m_wr));
    chk("pixel_addr", int'(pixel_addr), int'(m_addr));
    chk("pixel_mask", int'(pixel_write_updated), int'(m_mask));
    chk("clear_active", int'(clear_active), int'(m_clr_on));
    chk("clear_addr", int'(clear_addr), m_clr_addr);
    chk("overrun", int'(overrun), int'(m_ovr));
  endtask

  // One clock cycle: drive inputs, check grants, advance model, check registers.
  task automatic drive(input bit fs, input bit ls, input bit r0, input logic [7:0] a0,
                       input logic [3:0] k0, input bit r1, input logic [7:0] a1,
                       input logic [3:0] k1);
    bit eg0, eg1;
    frame_start = fs; line_start = ls;
    req0 = r0; req0_addr = a0; req0_mask = k0;
    req1 = r1; req1_addr = a1; req1_mask = k1;
    eg0 = 0; eg1 = 0;
    if (m_active && !fs && !ls) begin
      if (r0 && r1) begin
        eg0 = m_last; eg1 = !m_last;
      end else begin
        eg0 = r0; eg1 = r1;
      end
    end
    #1;
    act_g0 = gnt0; act_g1 = gnt1;
    chk("gnt0", int'(gnt0), int'(eg0));
    chk("gnt1", int'(gnt1), int'(eg1));
    @(posedge clk);
    if (eg0) begin
      m_last = 0; m_wr = 1; m_addr = a0; m_mask = k0;
    end else if (eg1) begin
      m_last = 1; m_wr = 1; m_addr = a1; m_mask = k1;
    end else begin
      m_wr = 0;
    end
    if (fs) begin
      m_active = 1; m_bank = 0; m_clr_on = 1; m_clr_addr = 0;
    end else if (m_active && ls) begin
      m_bank = (m_bank + 1) % 3;
      if (m_clr_on) m_ovr = 1;
      m_clr_on = 1; m_clr_addr = 0;
    end else if (m_clr_on) begin
      if (m_clr_addr == 255) begin
        m_clr_on = 0; m_clr_addr = 0;
      end else begin
        m_clr_addr++;
      end
    end
    #1;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    frame_start = 0; line_start = 0; req0 = 0; req1 = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_regs();
    reset_n = 1;
  endtask

  typedef struct {
    bit fs, ls, r0, r1, eg0, eg1, ewr;
    logic [7:0] eaddr;
    logic [3:0] emask;
    logic [1:0] esw;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int cnt, last_addr, guard;
    bit p0, p1;
    logic [7:0] a0, a1;
    logic [3:0] k0, k1;

    tbl[0]  = '{1, 0, 1, 1, 0, 0, 0, 8'h00, 4'h0, 2'd0};
    tbl[1]  = '{0, 0, 1, 1, 1, 0, 1, 8'h10, 4'hF, 2'd0};
    tbl[2]  = '{0, 0, 1, 1, 0, 1, 1, 8'h20, 4'h3, 2'd0};
    tbl[3]  = '{0, 0, 1, 1, 1, 0, 1, 8'h10, 4'hF, 2'd0};
    tbl[4]  = '{0, 1, 1, 1, 0, 0, 0, 8'h10, 4'hF, 2'd1};
    tbl[5]  = '{0, 0, 1, 1, 0, 1, 1, 8'h20, 4'h3, 2'd1};
    tbl[6]  = '{0, 0, 1, 0, 1, 0, 1, 8'h10, 4'hF, 2'd1};
    tbl[7]  = '{0, 0, 0, 1, 0, 1, 1, 8'h20, 4'h3, 2'd1};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 8'h20, 4'h3, 2'd1};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 8'h20, 4'h3, 2'd2};
    tbl[10] = '{1, 1, 0, 0, 0, 0, 0, 8'h20, 4'h3, 2'd0};
    tbl[11] = '{0, 1, 1, 0, 0, 0, 0, 8'h20, 4'h3, 2'd1};

    do_reset();
    // Grants must stay off in IDLE, and line_start must not rotate.
    drive(0, 1, 1, 8'h10, 4'hF, 1, 8'h20, 4'h3);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].fs, tbl[i].ls, tbl[i].r0, 8'h10, 4'hF, tbl[i].r1, 8'h20, 4'h3);
      chk("tbl_gnt0", int'(act_g0), int'(tbl[i].eg0));
      chk("tbl_gnt1", int'(act_g1), int'(tbl[i].eg1));
      chk("tbl_wr", int'(write_pixel), int'(tbl[i].ewr));
      chk("tbl_addr", int'(pixel_addr), int'(tbl[i].eaddr));
      chk("tbl_mask", int'(pixel_write_updated), int'(tbl[i].emask));
      chk("tbl_sw", int'(update_switch), int'(tbl[i].esw));
    end

    // Sweep length after frame_start.
    do_reset();
    drive(1, 0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0);
    chk("sweep_first_addr", int'(clear_addr), 0);
    cnt = 0; last_addr = -1; guard = 0;
    while (clear_active && guard < 400) begin
      cnt++; last_addr = int'(clear_addr); guard++;
      idle(1);
    end
    chk("sweep_len", cnt, 256);
    chk("sweep_last_addr", last_addr, 255);

    // Four well-spaced line_starts: no overrun.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0);
      chk("rot_sw", int'(update_switch), (i + 1) % 3);
      idle(299);
    end
    chk("no_overrun", int'(overrun), 0);

    // Early line_start sets sticky overrun, survives frame_start.
    drive(0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0);
    idle(99);
    drive(0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0);
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_restart", int'(clear_addr), 0);
    drive(1, 0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0);
    chk("overrun_sticky", int'(overrun), 1);

    // Request held over a boundary cycle is granted the cycle after.
    idle(3);
    drive(0, 1, 1, 8'h44, 4'h5, 0, 8'h00, 4'h0);
    chk("bnd_gnt0", int'(act_g0), 0);
    drive(0, 0, 1, 8'h44, 4'h5, 0, 8'h00, 4'h0);
    chk("bnd_after_wr", int'(write_pixel), 1);
    chk("bnd_after_gnt0", int'(act_g0), 1);

    // Asynchronous reset mid-sweep with a write in flight.
    reset_n = 0;
    #1;
    chk("arst_clear_active", int'(clear_active), 0);
    chk("arst_write", int'(write_pixel), 0);
    chk("arst_overrun", int'(overrun), 0);
    chk("arst_addr", int'(pixel_addr), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    drive(0, 1, 1, 8'h12, 4'h1, 0, 8'h00, 4'h0);
    chk("post_rst_ls_ignored", int'(update_switch), 0);
    chk("post_rst_no_sweep", int'(clear_active), 0);

    // Randomized traffic against the model.
    drive(1, 0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0);
    p0 = 0; p1 = 0; a0 = 8'h00; a1 = 8'h00; k0 = 4'h0; k1 = 4'h0;
    for (int i = 0; i < 4000; i++) begin
      bit fs, ls;
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; a0 = 8'($urandom); k0 = 4'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; a1 = 8'($urandom); k1 = 4'($urandom);
      end
      fs = ($urandom_range(0, 999) == 0);
      ls = ($urandom_range(0, 199) == 0);
      drive(fs, ls, p0, a0, k0, p1, a1, k1);
      if (act_g0) p0 = 0;
      if (act_g1) p1 = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_scheduler.md
Name: line_buffer_scheduler

Overview:
- Sequences the three-bank pixel-updated flag store.
- Rotates `update_switch` once per scanline and generates the clear-sweep address for the bank being cleared.
- Round-robin arbitrates two renderers (background, sprite) onto the single pixel-flag write port, so the update bank receives at most one write per cycle.
- Sits between the VGA timing generator and the line buffer / pixel-updated storage.

Parameters:
- ADDR_W, 8, pixel-flag address width (one entry per 4-pixel group).
- CLEAR_LEN, 256, number of entries swept per clear pass; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- line_start  in  1  one-cycle pulse at each scanline boundary.
- req0  in  1  requester 0 (background) write request.
- req0_addr  in  ADDR_W  requester 0 flag address.
- req0_mask  in  4  requester 0 per-pixel updated mask.
- req1  in  1  requester 1 (sprite) write request.
- req1_addr  in  ADDR_W  requester 1 flag address.
- req1_mask  in  4  requester 1 per-pixel updated mask.
- gnt0  out  1  requester 0 accepted this cycle (combinational).
- gnt1  out  1  requester 1 accepted this cycle (combinational).
- update_switch  out  2  bank rotation select, values 0..2 only.
- pixel_addr  out  ADDR_W  registered write address to flag store.
- write_pixel  out  1  registered write strobe.
- pixel_write_updated  out  4  registered write mask.
- clear_addr  out  ADDR_W  clear-sweep address.
- clear_active  out  1  clear sweep in progress.
- overrun  out  1  sticky: line_start arrived before clear sweep finished.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - update_switch=0, pixel_addr=0, write_pixel=0, pixel_write_updated=0.
  - clear_addr=0, clear_active=0, overrun=0, rr_last=1 (so req0 wins first contention).
  - gnt0=gnt1=0.
  - Reset mid-sweep or mid-write aborts immediately; there is no pending write after release.
- States:
  - IDLE: no grants, no rotation; line_start ignored. frame_start → ACTIVE.
  - ACTIVE: normal operation. frame_start while ACTIVE stays ACTIVE.
- frame_start (ACTIVE or IDLE), effective at the next edge:
  - update_switch←0.
  - clear_addr←0, clear_active←1.
  - Overrides a simultaneous line_start.
- line_start in ACTIVE (without frame_start), effective at the next edge:
  - update_switch advances 0→1→2→0.
  - clear_addr←0, clear_active←1.
  - If clear_active was 1 in that cycle, overrun←1; the sweep restarts anyway.
- Clear sweep:
  - While clear_active=1, clear_addr increments by 1 each cycle.
  - On the cycle clear_addr==CLEAR_LEN-1: clear_active←0 and clear_addr←0 at the next edge.
  - Sweep length is exactly CLEAR_LEN cycles with clear_active high.
- Arbitration, grants combinational:
  - Grants only in ACTIVE, and only when line_start=0 and frame_start=0 (boundary cycle blocks all grants).
  - Only one requester: grant it.
  - Both requesting: grant the one ≠ rr_last; rr_last←granted index on each grant.
  - Transfer occurs at the edge where req&gnt.
  - Requester holds req/addr/mask stable until granted.
- Write latency:
  - Granted addr/mask appear on pixel_addr/pixel_write_updated with write_pixel=1 one cycle after grant.
  - write_pixel=0 in any cycle following a no-grant cycle; pixel_addr/mask hold their last value.
  - A write issued in the boundary cycle itself uses the pre-rotation update_switch (rotation lands at the end of that cycle).
- overrun clears only on reset.
- update_switch is never 3.

Test Plan:
- Reset, then frame_start pulse → next cycle: update_switch=0, clear_active=1, clear_addr=0; clear_active high exactly 256 cycles (clear_addr 0..255), then 0.
- Four line_start pulses spaced 300 cycles apart → update_switch 1,2,0,1; overrun stays 0.
- line_start 100 cycles after previous line_start → overrun=1, clear_addr restarts at 0; overrun remains 1 after a following frame_start.
- req0 and req1 held high continuously with addr 0x10/0x20, masks 0xF/0x3 → gnt0,gnt1 alternate starting with gnt0; write_pixel=1 every cycle; pixel_addr sequence 0x10,0x20,0x10… one cycle after each grant.
- req0 high during a line_start cycle → gnt0=0 that cycle, granted next cycle; write_pixel=0 in the cycle after the boundary.
- frame_start and line_start asserted together while update_switch=2 → update_switch=0 (not rotated); reset_n pulsed low mid-sweep → all outputs 0 immediately, and line_start is ignored until the next frame_start.
